dsp_mac_sequencer: RTL and testbench
====================================

# dsp_mac_sequencer

Controller that runs dot-product jobs on one DSP slice instance (DSP48A1-style `DSP` module, default register configuration: A1/B1, M, P, OPMODE registered). It accepts a job length, streams operand pairs into the slice with a valid/ready handshake, and drives per-pair OPMODE and clock enables so the first product loads P and the rest accumulate. Each bubble keeps the slice's pipeline aligned. It returns the 48-bit accumulated result plus a sticky carry flag on a valid/ready result port. The slice's D, C, BCIN, PCIN and CARRYIN pins are tied off outside this block.

## Interface
- LEN_W, 8: width of the job length field; max job = 2^LEN_W − 1 pairs.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  job request; accepted only in IDLE.
- len  in  LEN_W  pair count, sampled on accepted start.
- busy  out  1  high in any state other than IDLE.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  operand pair accepted when in_valid && in_ready.
- in_a, in_b  in  18 each  signed operands.
- res_valid  out  1  result valid; held until res_ready.
- res_ready  in  1  result consumer ready.
- res_data  out  48  accumulated sum (two's complement).
- res_carry  out  1  OR of slice CARRYOUT over all accumulate steps of the job.
- dsp_a, dsp_b  out  18 each  to slice A, B.
- dsp_cea, dsp_ceb  out  1 each  A/B register enables.
- dsp_cem, dsp_cep, dsp_ceopmode  out  1 each  M/P/OPMODE register enables.
- dsp_opmode  out  8  to slice OPMODE.
- dsp_rstm, dsp_rstp  out  1 each  slice M/P resets (= rst, combinational).
- dsp_p  in  48  slice P output.
- dsp_carryout  in  1  slice CARRYOUT.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: if start, latch len and clear the issue counter and sticky carry.
  - len = 0 → DONE with res_data = 0 and res_carry = 0.
  - len > 0 → RUN.
- RUN:
  - in_ready = 1 while issued < len.
  - On accept: dsp_a = in_a and dsp_b = in_b (combinational pass-through); dsp_cea = dsp_ceb = 1. Otherwise cea = ceb = 0.
  - Counter increments per accept; RUN → DRAIN in the cycle the len-th pair is accepted.
- Per accepted pair at cycle t:
  - t+1: dsp_ceopmode = 1 and dsp_cem = 1 (registered outputs). dsp_opmode = 8'h01 (X = M, Z = 0) for the first pair of the job, else 8'h09 (X = M, Z = P). Bits [7:4] are always 0: add, no pre-adder, no carry-in.
  - t+2: dsp_cep = 1.
  - t+3: P and CARRYOUT reflect this pair; the block ORs dsp_carryout into the sticky carry, except for the first pair.
- Stall cycles: all slice enables for that slot are 0, so the slice holds state. Stalls never corrupt the sum.
- DRAIN: wait for the valid pipe (3 deep) to empty. In the cycle the last pair's P is visible (t_last+3), register dsp_p into res_data and the final sticky carry into res_carry; go to DONE.
- DONE:
  - res_valid = 1; res_data and res_carry are stable.
  - On res_valid && res_ready → IDLE.
  - start is ignored in every state except IDLE.
- Arithmetic: 18×18 signed products are sign-extended to 48 bits by the slice. The accumulation wraps modulo 2^48; the wrap is reported only through res_carry.
- Reset (any state, mid-job included): next state IDLE.
  - Registered outputs clear: busy, in_ready, res_valid, all dsp_ce*, res_data, res_carry = 0; dsp_opmode = 8'h00.
  - dsp_rstm and dsp_rstp are high for the reset cycles.
  - Pairs in flight are discarded.

## Timing
- Accept start at cycle s, then RUN from s+1; the first pair can be accepted at s+1.
- len = 0: res_valid at s+1.
- Last pair accepted at t_last: res_valid rises at t_last+4.
- Back-to-back operands, N pairs: res_valid at s+N+4.
- in_ready is a registered function of state/counter only; it is not dependent on in_valid.
- Result consumed at cycle r: IDLE at r+1; next start accepted at r+1 at the earliest.

## Test plan
- Reset: hold rst 3 cycles with random inputs → all outputs 0; dsp_rstm = dsp_rstp = 1.
- Basic job: len = 3, pairs (10,20), (3,4), (5,6) back-to-back from s+1.
  - res_data = 242, res_carry = 0, res_valid at s+7.
  - opmode sequence 01, 09, 09; cem/cep pulses at the required offsets.
- Stalls: same job with in_valid low for 2 cycles between pairs 1–2 and 1 cycle between pairs 2–3 → res_data = 242; no cep in bubble slots.
- Carry and negatives: len = 2, pairs (18'h3FFFF, 1), (1, 1) → res_data = 0, res_carry = 1.
  - Follow with len = 1, pair (−7, 6) → res_data = 48'hFFFF_FFFF_FFD6, res_carry = 0 (sticky flag cleared per job).
- Edges:
  - len = 0 → res_valid at s+1 with 0.
  - res_ready held low 5 cycles → result stable and start ignored; IDLE the cycle after res_ready.
- Reset mid-job: rst during DRAIN of a len = 3 job → IDLE next cycle, no res_valid; a new len = 1 job (2, 3) returns 6.

Source files
------------

// File: rtl/dsp_mac_sequencer.sv
// Dot-product sequencer for a single DSP48A1-style slice.
// Operand pairs stream through the A1/B1 -> M -> P pipeline. The first
// pair of a job loads P and each later pair accumulates into it.
//
// state | meaning
// IDLE  | waiting for a job request
// RUN   | accepting operand pairs and issuing them to the slice
// DRAIN | all pairs issued, waiting for the last product to reach P
// DONE  | result held on the result port until consumed
module dsp_mac_sequencer #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [17:0]      in_a,
  input  logic [17:0]      in_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [47:0]      res_data,
  output logic             res_carry,
  output logic [17:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic             dsp_cea,
  output logic             dsp_ceb,
  output logic             dsp_cem,
  output logic             dsp_cep,
  output logic             dsp_ceopmode,
  output logic [7:0]       dsp_opmode,
  output logic             dsp_rstm,
  output logic             dsp_rstp,
  input  logic [47:0]      dsp_p,
  input  logic             dsp_carryout
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [7:0] OPM_LOAD = 8'h01;  // X = M, Z = 0
  localparam logic [7:0] OPM_ACC  = 8'h09;  // X = M, Z = P

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] issued;
  logic [LEN_W-1:0] issued_inc;
  logic             in_ready_q;
  logic             start_acc;
  logic             accept;
  logic             first_acc;
  logic             last_acc;

  // Valid pipe tracking each issued pair through A1/B1 -> M -> P.
  // f* marks the first pair of the job, whose CARRYOUT is not meaningful.
  logic             v1, v2, v3;
  logic             f1, f2, f3;
  logic [7:0]       opmode_q;

  logic             sticky;
  logic             step_carry;
  logic             last_visible;

  logic             res_valid_q;
  logic [47:0]      res_data_q;
  logic             res_carry_q;

  assign start_acc    = (state == S_IDLE) && start;
  assign accept       = in_valid && in_ready_q;
  assign issued_inc   = issued + 1'b1;
  assign first_acc    = (issued == '0);
  assign last_acc     = accept && (issued_inc == len_q);
  assign step_carry   = v3 && !f3 && dsp_carryout;
  // In DRAIN no new pairs enter, so an occupied last stage behind an
  // empty pipe can only be the final pair of the job.
  assign last_visible = (state == S_DRAIN) && v3 && !v2 && !v1;

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (last_acc) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (last_visible) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Job length latch and issue counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q  <= '0;
      issued <= '0;
    end else if (start_acc) begin
      len_q  <= len;
      issued <= '0;
    end else if (accept) begin
      issued <= issued_inc;
    end
  end

  // Operand-side ready: registered, raised on entry to RUN and dropped
  // once the last pair has been taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_q <= 1'b0;
    end else if (start_acc) begin
      in_ready_q <= (len != '0);
    end else if (last_acc) begin
      in_ready_q <= 1'b0;
    end
  end

  // Slice pipeline tracking and per-pair OPMODE selection.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      v3       <= 1'b0;
      f1       <= 1'b0;
      f2       <= 1'b0;
      f3       <= 1'b0;
      opmode_q <= 8'h00;
    end else begin
      v1 <= accept;
      f1 <= accept && first_acc;
      v2 <= v1;
      f2 <= f1;
      v3 <= v2;
      f3 <= f2;
      if (accept) begin
        opmode_q <= first_acc ? OPM_LOAD : OPM_ACC;
      end
    end
  end

  // Sticky carry over all accumulate steps of the current job.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky <= 1'b0;
    end else if (start_acc) begin
      sticky <= 1'b0;
    end else if (step_carry) begin
      sticky <= 1'b1;
    end
  end

  // Result capture and hold until the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
    end else if (start_acc && (len == '0)) begin
      res_valid_q <= 1'b1;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
    end else if (last_visible) begin
      res_valid_q <= 1'b1;
      res_data_q  <= dsp_p;
      res_carry_q <= sticky | step_carry;
    end else if ((state == S_DONE) && res_ready) begin
      res_valid_q <= 1'b0;
    end
  end

  // Slice drive: A/B pass through only on an accepted pair so idle slots
  // present zeros; M/OPMODE/P enables follow the valid pipe.
  always_comb begin
    dsp_a        = accept ? in_a : 18'd0;
    dsp_b        = accept ? in_b : 18'd0;
    dsp_cea      = accept;
    dsp_ceb      = accept;
    dsp_cem      = v1;
    dsp_ceopmode = v1;
    dsp_cep      = v2;
    dsp_opmode   = opmode_q;
    dsp_rstm     = rst;
    dsp_rstp     = rst;
  end

  assign busy      = (state != S_IDLE);
  assign in_ready  = in_ready_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_carry = res_carry_q;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer with a behavioural DSP48A1-style slice.
module tb_dsp_mac_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic        busy;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] in_a;
  logic [17:0] in_b;
  logic        res_valid;
  logic        res_ready;
  logic [47:0] res_data;
  logic        res_carry;
  logic [17:0] dsp_a;
  logic [17:0] dsp_b;
  logic        dsp_cea, dsp_ceb, dsp_cem, dsp_cep, dsp_ceopmode;
  logic [7:0]  dsp_opmode;
  logic        dsp_rstm, dsp_rstp;
  logic [47:0] dsp_p;
  logic        dsp_carryout;

  dsp_mac_sequencer #(.LEN_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_carry(res_carry), .dsp_a(dsp_a), .dsp_b(dsp_b),
    .dsp_cea(dsp_cea), .dsp_ceb(dsp_ceb), .dsp_cem(dsp_cem),
    .dsp_cep(dsp_cep), .dsp_ceopmode(dsp_ceopmode),
    .dsp_opmode(dsp_opmode), .dsp_rstm(dsp_rstm), .dsp_rstp(dsp_rstp),
    .dsp_p(dsp_p), .dsp_carryout(dsp_carryout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural slice: A1/B1, M, P (with CARRYOUT) and OPMODE registered.
  logic [17:0]        a1_r = '0;
  logic [17:0]        b1_r = '0;
  logic [47:0]        m_r = '0;
  logic [47:0]        p_r = '0;
  logic               co_r = 1'b0;
  logic [7:0]         opm_r = '0;
  logic signed [35:0] sa1, sb1, sprod;
  logic [47:0]        xm, zm;

  always_comb begin
    sa1   = {{18{a1_r[17]}}, a1_r};
    sb1   = {{18{b1_r[17]}}, b1_r};
    sprod = sa1 * sb1;
    xm    = (opm_r[1:0] == 2'b01) ? m_r : 48'd0;
    zm    = (opm_r[3:2] == 2'b10) ? p_r : 48'd0;
  end

  always @(posedge clk) begin
    if (dsp_cea) a1_r <= dsp_a;
    if (dsp_ceb) b1_r <= dsp_b;
    if (dsp_rstm) m_r <= '0;
    else if (dsp_cem) m_r <= {{12{sprod[35]}}, sprod};
    if (dsp_ceopmode) opm_r <= dsp_opmode;
    if (dsp_rstp) {co_r, p_r} <= '0;
    else if (dsp_cep) {co_r, p_r} <= {1'b0, zm} + {1'b0, xm};
  end

  assign dsp_p        = p_r;
  assign dsp_carryout = co_r;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Job description and logs.
  logic [17:0] job_a[$];
  logic [17:0] job_b[$];
  int          job_gap[$];
  int          acc_log[$];
  int          cem_log[$];
  int          cep_log[$];
  logic [7:0]  op_log[$];
  int          ceop_n;
  logic [48:0] sb_q[$];
  logic [47:0] last_data;
  logic        last_carry;
  int          valid_cyc;

  // Scoreboard pop and slice-enable logging, sampled mid-cycle.
  always @(negedge clk) begin
    if (dsp_cem === 1'b1) begin
      cem_log.push_back(cyc);
      op_log.push_back(dsp_opmode);
    end
    if (dsp_ceopmode === 1'b1) ceop_n++;
    if (dsp_cep === 1'b1) cep_log.push_back(cyc);
    if (res_valid === 1'b1 && res_ready === 1'b1) begin
      last_data  = res_data;
      last_carry = res_carry;
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_result", 64'(res_valid), 64'(0));
      end else begin
        logic [48:0] e;
        e = sb_q.pop_front();
        chk("sb_res_data", 64'(res_data), 64'(e[47:0]));
        chk("sb_res_carry", 64'(res_carry), 64'(e[48]));
      end
    end
  end

  function automatic logic [48:0] model(input int n);
    logic [47:0]        acc;
    logic [47:0]        prod;
    logic               c, cy;
    logic signed [35:0] ea, eb, p36;
    acc = '0;
    c   = 1'b0;
    for (int i = 0; i < n; i++) begin
      ea   = {{18{job_a[i][17]}}, job_a[i]};
      eb   = {{18{job_b[i][17]}}, job_b[i]};
      p36  = ea * eb;
      prod = {{12{p36[35]}}, p36};
      if (i == 0) acc = prod;
      else begin
        {cy, acc} = {1'b0, acc} + {1'b0, prod};
        c = c | cy;
      end
    end
    return {c, acc};
  endfunction

  task automatic clear_job();
    job_a.delete();
    job_b.delete();
    job_gap.delete();
  endtask

  task automatic add_pair(input logic [17:0] a, input logic [17:0] b, input int gap);
    job_a.push_back(a);
    job_b.push_back(b);
    job_gap.push_back(gap);
  endtask

  task automatic feed_job(input int n, input bit push_exp, output int s, output int t_last,
                          output logic [48:0] e);
    int guard;
    acc_log.delete();
    cem_log.delete();
    cep_log.delete();
    op_log.delete();
    ceop_n = 0;
    e = model(n);
    if (push_exp) sb_q.push_back(e);
    start  = 1'b1;
    len    = 8'(n);
    s      = cyc;
    t_last = s;
    @(posedge clk); #1;
    start = 1'b0;
    len   = 8'd0;
    for (int i = 0; i < n; i++) begin
      repeat (job_gap[i]) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_a     = job_a[i];
      in_b     = job_b[i];
      guard    = 0;
      while (in_ready !== 1'b1 && guard < 20) begin
        @(posedge clk); #1;
        guard++;
      end
      chk("in_ready_wait", 64'(guard), 64'(0));
      if (guard >= 20) break;
      acc_log.push_back(cyc);
      t_last = cyc;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
  endtask

  task automatic wait_result(input int n, input int s, input int t_last, input int hold,
                             input logic [48:0] e);
    int guard;
    int ncem, ncep;
    guard = 0;
    while (res_valid !== 1'b1 && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    valid_cyc = cyc;
    chk("res_valid_cycle", 64'(cyc), 64'((n == 0) ? s + 1 : t_last + 4));
    // Result held with consumer stalled; start requests must be ignored.
    res_ready = 1'b0;
    start     = 1'b1;
    len       = 8'd4;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", 64'(res_valid), 64'(1));
      chk("hold_data", 64'(res_data), 64'(e[47:0]));
      chk("hold_no_ready", 64'(in_ready), 64'(0));
    end
    start     = 1'b0;
    len       = 8'd0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("idle_after_consume", 64'(busy), 64'(0));
    chk("valid_drop", 64'(res_valid), 64'(0));
    if (n > 0) begin
      ncem = cem_log.size();
      ncep = cep_log.size();
      chk("cem_count", 64'(ncem), 64'(n));
      chk("cep_count", 64'(ncep), 64'(n));
      chk("ceopmode_count", 64'(ceop_n), 64'(n));
      for (int i = 0; i < n && i < ncem && i < ncep && i < acc_log.size(); i++) begin
        chk("cem_offset", 64'(cem_log[i]), 64'(acc_log[i] + 1));
        chk("cep_offset", 64'(cep_log[i]), 64'(acc_log[i] + 2));
        chk("opmode_seq", 64'(op_log[i]), 64'((i == 0) ? 8'h01 : 8'h09));
      end
    end
  endtask

  task automatic run_job(input int n, input int hold);
    int          s, t;
    logic [48:0] e;
    feed_job(n, 1'b1, s, t, e);
    wait_result(n, s, t, hold, e);
  endtask

  initial begin
    int          s, t, saw;
    logic [48:0] e;
    rst       = 1'b1;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    res_ready = 1'b0;

    // Reset with random inputs.
    repeat (3) begin
      start     = 1'($urandom);
      len       = 8'($urandom);
      in_valid  = 1'($urandom);
      in_a      = 18'($urandom);
      in_b      = 18'($urandom);
      res_ready = 1'($urandom);
      @(posedge clk); #1;
    end
    chk("rst_ctrl", 64'({busy, in_ready, res_valid, res_carry, dsp_cea, dsp_ceb,
                         dsp_cem, dsp_cep, dsp_ceopmode}), 64'(0));
    chk("rst_res_data", 64'(res_data), 64'(0));
    chk("rst_opmode", 64'(dsp_opmode), 64'(0));
    chk("rst_dsp_ab", 64'({dsp_a, dsp_b}), 64'(0));
    chk("rst_rstm_rstp", 64'({dsp_rstm, dsp_rstp}), 64'(3));
    rst = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
    in_a = '0; in_b = '0; res_ready = 1'b0;
    @(posedge clk); #1;
    chk("rstmp_release", 64'({dsp_rstm, dsp_rstp}), 64'(0));

    // Basic back-to-back job.
    clear_job();
    add_pair(18'd10, 18'd20, 0);
    add_pair(18'd3, 18'd4, 0);
    add_pair(18'd5, 18'd6, 0);
    feed_job(3, 1'b1, s, t, e);
    wait_result(3, s, t, 0, e);
    chk("basic_valid_s7", 64'(valid_cyc), 64'(s + 7));
    chk("basic_data", 64'(last_data), 64'(242));
    chk("basic_carry", 64'(last_carry), 64'(0));

    // Same job with bubbles between pairs.
    clear_job();
    add_pair(18'd10, 18'd20, 0);
    add_pair(18'd3, 18'd4, 2);
    add_pair(18'd5, 18'd6, 1);
    run_job(3, 1);
    chk("stall_data", 64'(last_data), 64'(242));

    // Wrap to zero with carry, then a negative single-pair job.
    clear_job();
    add_pair(18'h3FFFF, 18'd1, 0);
    add_pair(18'd1, 18'd1, 0);
    run_job(2, 0);
    chk("carry_data", 64'(last_data), 64'(0));
    chk("carry_flag", 64'(last_carry), 64'(1));
    clear_job();
    add_pair(18'h3FFF9, 18'd6, 0);
    run_job(1, 0);
    chk("neg_data", 64'(last_data), 64'(48'hFFFF_FFFF_FFD6));
    chk("neg_carry", 64'(last_carry), 64'(0));

    // Zero-length job, consumer stalled five cycles.
    clear_job();
    run_job(0, 5);
    chk("len0_data", 64'(last_data), 64'(0));

    // Random jobs.
    for (int j = 0; j < 6; j++) begin
      int n;
      n = int'($urandom_range(1, 6));
      clear_job();
      for (int i = 0; i < n; i++)
        add_pair(18'($urandom), 18'($urandom), (i == 0) ? 0 : int'($urandom_range(0, 2)));
      run_job(n, int'($urandom_range(0, 2)));
    end

    // Reset while draining a job.
    clear_job();
    add_pair(18'd7, 18'd8, 0);
    add_pair(18'd9, 18'd10, 0);
    add_pair(18'd11, 18'd12, 0);
    feed_job(3, 1'b0, s, t, e);
    @(posedge clk); #1;
    chk("drain_busy", 64'(busy), 64'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_idle", 64'(busy), 64'(0));
    chk("midrst_no_valid", 64'(res_valid), 64'(0));
    saw = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (res_valid !== 1'b0) saw++;
    end
    chk("midrst_no_late_valid", 64'(saw), 64'(0));
    clear_job();
    add_pair(18'd2, 18'd3, 0);
    run_job(1, 0);
    chk("postrst_data", 64'(last_data), 64'(6));

    chk("sb_leftover", 64'(sb_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
